// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: state encoding and default widths shared with the multiplier
package product_accumulator_pkg;
    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;
    localparam int PW_DEF    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int COUNT_DEF = 16;
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input stream and block result stream
interface product_accumulator_if #(
    parameter int PW    = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums blocks of up to COUNT unsigned products and emits sum, count and overflow
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int COUNT = COUNT_DEF,
    parameter int CNT_W = $clog2(COUNT + 1)
) (
    input logic                 clk,
    input logic                 rst,
    product_accumulator_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, r_out_sum;
    logic [CNT_W-1:0] r_cnt, r_out_count;
    logic             r_ovf, r_out_ovf;
    logic [ACC_W:0]   w_nxt;
    logic             w_accept, w_close;

    assign w_accept = bus.in_valid & (r_state == ST_ACC);
    assign w_nxt    = {1'b0, r_acc} + {{(ACC_W + 1 - PW){1'b0}}, bus.in_prod};
    assign w_close  = w_accept & (bus.in_last | (r_cnt == CNT_W'(COUNT - 1)));

    // next state: close a block into HOLD, release it on out_ready
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_ACC && w_close)
            w_state_nxt = ST_HOLD;
        else if (r_state == ST_HOLD && bus.out_ready)
            w_state_nxt = ST_ACC;
    end

    // state register, running accumulator and registered block result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_close) begin
                r_out_sum   <= w_nxt[ACC_W-1:0];
                r_out_count <= r_cnt + 1'b1;
                r_out_ovf   <= r_ovf | w_nxt[ACC_W];
            end else if (w_accept) begin
                r_acc <= w_nxt[ACC_W-1:0];
                r_cnt <= r_cnt + 1'b1;
                r_ovf <= r_ovf | w_nxt[ACC_W];
            end
            if (r_state == ST_HOLD && bus.out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_ACC);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;
endmodule
